regfile_write_scheduler: RTL
============================

# regfile_write_scheduler

Write-port scheduler for the 32x32 register file. It shares the file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit. It registers the winning write onto the file's `regWrite`/`writeReg`/`writeData` inputs and keeps a pending-destination scoreboard so decode can stall on registers whose mul/div result has not yet landed. It sits between the writeback mux and the register file.

## Interface
- `STARVE_LIMIT`, default 3: number of consecutive contended losses by mul/div before it gets priority (range 1..15).
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `wb_valid`  in  1  writeback request.
- `wb_reg`  in  5  writeback destination.
- `wb_data`  in  32  writeback data.
- `wb_ready`  out  1  writeback grant (combinational).
- `md_valid`  in  1  mul/div result request.
- `md_reg`  in  5  mul/div destination.
- `md_data`  in  32  mul/div data.
- `md_ready`  out  1  mul/div grant (combinational).
- `issue_valid`  in  1  a mul/div op was issued this cycle.
- `issue_reg`  in  5  its destination, to be marked pending.
- `chk_reg1`, `chk_reg2`  in  5 each  decode source registers.
- `hazard`  out  1  a checked source is pending (combinational).
- `regWrite`  out  1  to register file, registered.
- `writeReg`  out  5  to register file, registered.
- `writeData`  out  32  to register file, registered.

## Operation
- A handshake completes on a side when its valid and ready are both 1 at a posedge. A requester holds valid, reg and data stable until it is granted.
- Mode is derived from `starve_cnt` (4-bit): boost = (`starve_cnt` == `STARVE_LIMIT`).
- Grant rules:
  - `wb_ready` = !(boost & `md_valid`).
  - `md_ready` = !`wb_valid` | boost.
  - At most one grant per cycle. With a single requester, it is always granted.
- `starve_cnt` update:
  - Increments when both sides are valid and wb wins.
  - Clears to 0 on any md grant.
  - Holds otherwise.
- Output register:
  - On a grant, load `writeReg`/`writeData` from the winner.
  - `regWrite` = 1 unless the destination is 0.
  - A grant to register 0 completes the handshake, writes nothing, and still clears the scoreboard as below (reg 0 is never set).
  - With no grant, `regWrite` goes to 0 and `writeReg`/`writeData` hold.
- Scoreboard `busy[31:0]`:
  - Set `busy[issue_reg]` on `issue_valid` when `issue_reg` != 0.
  - Clear `busy[md_reg]` on an md grant.
  - Set and clear of the same register in the same cycle: set wins.
  - `busy[0]` is constantly 0.
- `hazard` = `busy[chk_reg1]` | `busy[chk_reg2]`, from registered state only. An issue in cycle N is visible in cycle N+1.

## Timing
- Grant is combinational in cycle N. `regWrite`/`writeReg`/`writeData` are valid in cycle N+1, and the file is written at the posedge ending N+1. Total latency is 2 edges.
- `busy` clears at the grant edge. `hazard` drops in cycle N+1, the same cycle the write is presented. Decode must stall one further cycle or forward from `writeData`.
- Sustained throughput is one write per cycle. Back-to-back grants produce continuous `regWrite` = 1.
- Reset (synchronous):
  - `regWrite`=0, `writeReg`=0, `writeData`=0, `busy`=0, `starve_cnt`=0.
  - `wb_ready`/`md_ready` follow the grant equations even while reset is high, but handshakes during reset are discarded and requesters must re-present.
- Reset mid-operation: a write presented in the reset cycle is not committed. `regWrite` is forced 0 from the reset edge.

## Structure
- Shared package `mips_pkg`:
  - `REG_ADDR_W`=5, `DATA_W`=32, `NUM_REGS`=32, `REG_ZERO`=5'd0.
  - Grant-source enum {`SRC_NONE`, `SRC_WB`, `SRC_MD`}.
- One natural sub-module, `reg_scoreboard`: the busy vector, set/clear/set-wins logic and the two-port hazard lookup.
- Arbitration, the starvation counter and the output register stay in the top module.

## Test plan
- Single writeback: `wb_valid` with reg 5, data 0xDEADBEEF in cycle 0 -> `wb_ready`=1 in cycle 0; `regWrite`=1, `writeReg`=5, `writeData`=0xDEADBEEF in cycle 1; `regWrite`=0 in cycle 2.
- Sustained contention with STARVE_LIMIT=3: both sides valid continuously -> wb granted in cycles 0,1,2; md granted in cycle 3 with `starve_cnt` returning to 0; wb granted again in cycle 4.
- Scoreboard: issue reg 9 in cycle 0 with `chk_reg1`=9 -> `hazard`=0 in cycle 0 and 1 in cycle 1. md grant for reg 9 in cycle 4 -> `hazard`=0 in cycle 5, `writeReg`=9 in cycle 5.
- Set wins: md grant for reg 7 together with issue of reg 7 in the same cycle -> `busy[7]` stays 1, and a write to reg 7 is still presented next cycle.
- Register zero: wb to reg 0 with data 0x12345678 -> `wb_ready`=1 but `regWrite`=0 next cycle. Issue of reg 0 -> `hazard`=0 for `chk_reg1`=0.
- Reset mid-operation: `busy[3]` set and md grant in progress, assert `reset` for 1 cycle -> next cycle `regWrite`=0, `hazard`=0 for all registers, `starve_cnt`=0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Purpose  : Shared register-file widths and write-port grant-source encoding.
// Revision : 1.0
// ============================================================================
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MD   = 2'd2
  } grant_src_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Pending-destination bit vector with a two-port hazard lookup.
// Revision : 1.0
// ============================================================================
module reg_scoreboard
  import mips_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  set_valid_i,
  input  logic [REG_ADDR_W-1:0] set_reg_i,
  input  logic                  clr_valid_i,
  input  logic [REG_ADDR_W-1:0] clr_reg_i,
  input  logic [REG_ADDR_W-1:0] chk_reg1_i,
  input  logic [REG_ADDR_W-1:0] chk_reg2_i,
  output logic                  hazard_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = set_valid_i ? (NUM_REGS'(1) << set_reg_i) : '0;
    clr_mask = clr_valid_i ? (NUM_REGS'(1) << clr_reg_i) : '0;
    // OR-ing the set after the clear makes a same-cycle issue win over retirement.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard_o = busy_q[chk_reg1_i] | busy_q[chk_reg2_i];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_scheduler
// Purpose  : Arbitrates the register-file write port between writeback and
//            mul/div, with starvation boost and a pending-destination scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_write_scheduler
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_ready,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  input  logic [REG_ADDR_W-1:0] chk_reg1,
  input  logic [REG_ADDR_W-1:0] chk_reg2,
  output logic                  hazard,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt_q;
  logic [3:0]  starve_cnt_d;
  logic        boost;
  logic        wb_fire;
  logic        md_fire;
  grant_src_e  grant_src;

  assign boost    = (starve_cnt_q == LIMIT);
  assign wb_ready = !(boost && md_valid);
  assign md_ready = !wb_valid || boost;
  assign wb_fire  = wb_valid && wb_ready;
  assign md_fire  = md_valid && md_ready;

  always_comb begin
    grant_src = SRC_NONE;
    if (md_fire) begin
      grant_src = SRC_MD;
    end else if (wb_fire) begin
      grant_src = SRC_WB;
    end
  end

  // Counter only advances while not boosted, so it never exceeds LIMIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (md_fire) begin
      starve_cnt_d = 4'd0;
    end else if (wb_fire && md_valid) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      regWrite     <= 1'b0;
      writeReg     <= '0;
      writeData    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (grant_src)
        SRC_WB: begin
          regWrite  <= (wb_reg != REG_ZERO);
          writeReg  <= wb_reg;
          writeData <= wb_data;
        end
        SRC_MD: begin
          regWrite  <= (md_reg != REG_ZERO);
          writeReg  <= md_reg;
          writeData <= md_data;
        end
        default: begin
          regWrite  <= 1'b0;
        end
      endcase
    end
  end

  reg_scoreboard u_scoreboard (
    .clk_i       (clock),
    .rst_i       (reset),
    .set_valid_i (issue_valid && (issue_reg != REG_ZERO)),
    .set_reg_i   (issue_reg),
    .clr_valid_i (md_fire),
    .clr_reg_i   (md_reg),
    .chk_reg1_i  (chk_reg1),
    .chk_reg2_i  (chk_reg2),
    .hazard_o    (hazard)
  );

endmodule : regfile_write_scheduler
`default_nettype wire
